// File: rtl/ascensor_n_pisos.sv
// rtl/ascensor_n_pisos.sv - N-floor SCAN elevator controller with tick divider and latched calls
module ascensor_n_pisos #(
    parameter int PISOS    = 4,
    parameter int DIV      = 4,
    parameter int T_VIAJE  = 2,
    parameter int T_PUERTA = 3,
    localparam int W       = (PISOS > 1) ? $clog2(PISOS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PISOS-1:0] llamada,
    output logic [W-1:0]     piso,
    output logic [1:0]       direccion,
    output logic             puertas_abiertas,
    output logic             state_andando,
    output logic [PISOS-1:0] pendientes,
    output logic             clk_nuevo
);

    localparam int CW = (DIV > 1)      ? $clog2(DIV)      : 1;
    localparam int VW = (T_VIAJE > 1)  ? $clog2(T_VIAJE)  : 1;
    localparam int PW = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {REPOSO, ANDANDO, PUERTAS} estado_t;

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nuevo_q, nuevo_d;
    logic [W-1:0]     piso_q, piso_d;
    logic [1:0]       dir_q, dir_d;
    logic             pref_q, pref_d;
    logic [VW-1:0]    viaje_q, viaje_d;
    logic [PW-1:0]    puerta_q, puerta_d;
    logic [PISOS-1:0] pend_q, pend_d;
    logic [PISOS-1:0] limpiar, entrada, bit_actual;
    logic             arriba_act, abajo_act, seguir;

    function automatic logic hay_arriba(input logic [PISOS-1:0] p, input logic [W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < PISOS; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic hay_abajo(input logic [PISOS-1:0] p, input logic [W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < PISOS; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        nuevo_d = 1'b0;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d   = '0;
            nuevo_d = 1'b1;
        end
    end

    assign bit_actual = PISOS'(1) << piso_q;
    assign arriba_act = hay_arriba(pend_q, piso_q);
    assign abajo_act  = hay_abajo(pend_q, piso_q);

    // The FSM only moves on divided ticks; pending bits are tracked every clk.
    always_comb begin
        estado_d = estado_q;
        piso_d   = piso_q;
        dir_d    = dir_q;
        pref_d   = pref_q;
        viaje_d  = viaje_q;
        puerta_d = puerta_q;
        limpiar  = '0;
        seguir   = 1'b0;
        if (nuevo_q) begin
            case (estado_q)
                REPOSO: begin
                    if (pend_q[piso_q]) begin
                        estado_d = PUERTAS;
                        puerta_d = '0;
                        limpiar  = bit_actual;
                    end else if (pref_q ? arriba_act : abajo_act) begin
                        estado_d = ANDANDO;
                        viaje_d  = '0;
                        dir_d    = pref_q ? DIR_UP : DIR_DOWN;
                    end else if (pref_q ? abajo_act : arriba_act) begin
                        estado_d = ANDANDO;
                        viaje_d  = '0;
                        dir_d    = pref_q ? DIR_DOWN : DIR_UP;
                        pref_d   = ~pref_q;
                    end
                end
                ANDANDO: begin
                    if (viaje_q == VW'(T_VIAJE - 1)) begin
                        viaje_d = '0;
                        piso_d  = (dir_q == DIR_UP) ? piso_q + 1'b1 : piso_q - 1'b1;
                        seguir  = (dir_q == DIR_UP) ? hay_arriba(pend_q, piso_d)
                                                    : hay_abajo(pend_q, piso_d);
                        if (pend_q[piso_d]) begin
                            estado_d = PUERTAS;
                            dir_d    = DIR_STOP;
                            puerta_d = '0;
                            limpiar  = PISOS'(1) << piso_d;
                        end else if (!seguir) begin
                            estado_d = REPOSO;
                            dir_d    = DIR_STOP;
                        end
                    end else begin
                        viaje_d = viaje_q + 1'b1;
                    end
                end
                PUERTAS: begin
                    if (puerta_q == PW'(T_PUERTA - 1)) begin
                        estado_d = REPOSO;
                    end else begin
                        puerta_d = puerta_q + 1'b1;
                    end
                end
                default: begin
                    estado_d = REPOSO;
                    dir_d    = DIR_STOP;
                end
            endcase
        end
    end

    // A call for the floor whose doors are open is already being served.
    always_comb begin
        entrada = llamada;
        if (estado_q == PUERTAS) entrada = llamada & ~bit_actual;
        pend_d = (pend_q | entrada) & ~limpiar;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            nuevo_q  <= 1'b0;
            piso_q   <= '0;
            dir_q    <= DIR_STOP;
            pref_q   <= 1'b1;
            viaje_q  <= '0;
            puerta_q <= '0;
            pend_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nuevo_q  <= nuevo_d;
            piso_q   <= piso_d;
            dir_q    <= dir_d;
            pref_q   <= pref_d;
            viaje_q  <= viaje_d;
            puerta_q <= puerta_d;
            pend_q   <= pend_d;
        end
    end

    assign piso             = piso_q;
    assign direccion        = dir_q;
    assign puertas_abiertas = (estado_q == PUERTAS);
    assign state_andando    = (estado_q == ANDANDO);
    assign pendientes       = pend_q;
    assign clk_nuevo        = nuevo_q;

endmodule

// File: tb/tb_ascensor_n_pisos.sv
// tb/tb_ascensor_n_pisos.sv - self-checking bench for ascensor_n_pisos (PISOS=4, DIV=4, T_VIAJE=2, T_PUERTA=3)
module tb_ascensor_n_pisos;

    logic       clk;
    logic       rst;
    logic [3:0] llamada;
    logic [1:0] piso;
    logic [1:0] direccion;
    logic       puertas_abiertas;
    logic       state_andando;
    logic [3:0] pendientes;
    logic       clk_nuevo;

    int checks = 0;
    int errors = 0;

    ascensor_n_pisos #(
        .PISOS   (4),
        .DIV     (4),
        .T_VIAJE (2),
        .T_PUERTA(3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .llamada         (llamada),
        .piso            (piso),
        .direccion       (direccion),
        .puertas_abiertas(puertas_abiertas),
        .state_andando   (state_andando),
        .pendientes      (pendientes),
        .clk_nuevo       (clk_nuevo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         scn;
        int         t_drive;
        logic [3:0] llam;
        int         t_check;
        logic [1:0] piso;
        logic [1:0] dir;
        logic       pa;
        logic       an;
        logic [3:0] pend;
    } vec_t;

    typedef struct {
        int         scn;
        int         t;
        logic [1:0] piso;
        logic [1:0] dir;
        logic       pa;
        logic       an;
        logic [3:0] pend;
    } exp_t;

    vec_t tabla[$];
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic do_reset(input int ciclos, input logic [3:0] llam);
        rst     = 1'b1;
        llamada = llam;
        repeat (ciclos) @(negedge clk);
        rst     = 1'b0;
        llamada = '0;
    endtask

    // Returns at the negedge right after the FSM update edge of the next tick.
    task automatic wait_tick();
        int n;
        n = 0;
        while (clk_nuevo !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("tick_timeout", n, 0);
        @(negedge clk);
    endtask

    task automatic count_to_pulse(input string name);
        int n;
        n = 0;
        while (clk_nuevo !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, 4);
    endtask

    task automatic run_scn(input int s);
        int         last;
        logic [3:0] acc;
        string      tag;
        last = 0;
        foreach (tabla[i]) if (tabla[i].scn == s && tabla[i].t_check > last) last = tabla[i].t_check;
        do_reset(3, 4'b0000);
        for (int t = 0; t <= last; t++) begin
            if (t > 0) wait_tick();
            acc = '0;
            foreach (tabla[i]) begin
                if (tabla[i].scn == s && tabla[i].t_drive == t) begin
                    acc |= tabla[i].llam;
                    sb.push_back('{s, tabla[i].t_check, tabla[i].piso, tabla[i].dir,
                                   tabla[i].pa, tabla[i].an, tabla[i].pend});
                end
            end
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].t == t) begin
                    tag = $sformatf("s%0d_t%0d", s, t);
                    chk({tag, "_piso"}, int'(piso), int'(sb[k].piso));
                    chk({tag, "_dir"}, int'(direccion), int'(sb[k].dir));
                    chk({tag, "_puertas"}, int'(puertas_abiertas), int'(sb[k].pa));
                    chk({tag, "_andando"}, int'(state_andando), int'(sb[k].an));
                    chk({tag, "_pend"}, int'(pendientes), int'(sb[k].pend));
                    sb.delete(k);
                end
            end
            if (acc != 4'b0000) begin
                llamada = acc;
                @(negedge clk);
                llamada = '0;
            end
        end
        chk($sformatf("s%0d_leftover", s), sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        llamada = '0;

        // scn, t_drive, llamada, t_check, piso, dir, puertas, andando, pendientes
        tabla.push_back('{2, 0, 4'b0100, 0, 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000});
        tabla.push_back('{2, 0, 4'b0000, 1, 2'd0, 2'b01, 1'b0, 1'b1, 4'b0100});
        tabla.push_back('{2, 0, 4'b0000, 2, 2'd0, 2'b01, 1'b0, 1'b1, 4'b0100});
        tabla.push_back('{2, 0, 4'b0000, 3, 2'd1, 2'b01, 1'b0, 1'b1, 4'b0100});
        tabla.push_back('{2, 0, 4'b0000, 5, 2'd2, 2'b00, 1'b1, 1'b0, 4'b0000});
        tabla.push_back('{2, 0, 4'b0000, 7, 2'd2, 2'b00, 1'b1, 1'b0, 4'b0000});
        tabla.push_back('{2, 0, 4'b0000, 8, 2'd2, 2'b00, 1'b0, 1'b0, 4'b0000});
        tabla.push_back('{2, 0, 4'b0000, 9, 2'd2, 2'b00, 1'b0, 1'b0, 4'b0000});

        tabla.push_back('{3, 0, 4'b1000, 0, 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000});
        tabla.push_back('{3, 0, 4'b0000, 1, 2'd0, 2'b01, 1'b0, 1'b1, 4'b1000});
        tabla.push_back('{3, 1, 4'b0010, 2, 2'd0, 2'b01, 1'b0, 1'b1, 4'b1010});
        tabla.push_back('{3, 1, 4'b0000, 3, 2'd1, 2'b00, 1'b1, 1'b0, 4'b1000});
        tabla.push_back('{3, 1, 4'b0000, 5, 2'd1, 2'b00, 1'b1, 1'b0, 4'b1000});
        tabla.push_back('{3, 1, 4'b0000, 6, 2'd1, 2'b00, 1'b0, 1'b0, 4'b1000});
        tabla.push_back('{3, 1, 4'b0000, 7, 2'd1, 2'b01, 1'b0, 1'b1, 4'b1000});
        tabla.push_back('{3, 1, 4'b0000, 9, 2'd2, 2'b01, 1'b0, 1'b1, 4'b1000});
        tabla.push_back('{3, 1, 4'b0000, 11, 2'd3, 2'b00, 1'b1, 1'b0, 4'b0000});
        tabla.push_back('{3, 1, 4'b0000, 14, 2'd3, 2'b00, 1'b0, 1'b0, 4'b0000});

        tabla.push_back('{4, 0, 4'b0100, 1, 2'd0, 2'b01, 1'b0, 1'b1, 4'b0100});
        tabla.push_back('{4, 0, 4'b0000, 8, 2'd2, 2'b00, 1'b0, 1'b0, 4'b0000});
        tabla.push_back('{4, 8, 4'b1001, 9, 2'd2, 2'b01, 1'b0, 1'b1, 4'b1001});
        tabla.push_back('{4, 8, 4'b0000, 11, 2'd3, 2'b00, 1'b1, 1'b0, 4'b0001});
        tabla.push_back('{4, 8, 4'b0000, 14, 2'd3, 2'b00, 1'b0, 1'b0, 4'b0001});
        tabla.push_back('{4, 8, 4'b0000, 15, 2'd3, 2'b10, 1'b0, 1'b1, 4'b0001});
        tabla.push_back('{4, 8, 4'b0000, 17, 2'd2, 2'b10, 1'b0, 1'b1, 4'b0001});
        tabla.push_back('{4, 8, 4'b0000, 19, 2'd1, 2'b10, 1'b0, 1'b1, 4'b0001});
        tabla.push_back('{4, 8, 4'b0000, 21, 2'd0, 2'b00, 1'b1, 1'b0, 4'b0000});
        tabla.push_back('{4, 8, 4'b0000, 24, 2'd0, 2'b00, 1'b0, 1'b0, 4'b0000});

        tabla.push_back('{5, 0, 4'b0001, 1, 2'd0, 2'b00, 1'b1, 1'b0, 4'b0000});
        tabla.push_back('{5, 1, 4'b0101, 2, 2'd0, 2'b00, 1'b1, 1'b0, 4'b0100});
        tabla.push_back('{5, 1, 4'b0000, 4, 2'd0, 2'b00, 1'b0, 1'b0, 4'b0100});
        tabla.push_back('{5, 1, 4'b0000, 5, 2'd0, 2'b01, 1'b0, 1'b1, 4'b0100});
        tabla.push_back('{5, 1, 4'b0000, 7, 2'd1, 2'b01, 1'b0, 1'b1, 4'b0100});
        tabla.push_back('{5, 1, 4'b0000, 9, 2'd2, 2'b00, 1'b1, 1'b0, 4'b0000});

        // Reset with all calls asserted, then the divider's first pulse.
        rst     = 1'b1;
        llamada = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_piso", int'(piso), 0);
        chk("rst_dir", int'(direccion), 0);
        chk("rst_puertas", int'(puertas_abiertas), 0);
        chk("rst_andando", int'(state_andando), 0);
        chk("rst_pend", int'(pendientes), 0);
        chk("rst_clk_nuevo", int'(clk_nuevo), 0);
        rst     = 1'b0;
        llamada = '0;
        count_to_pulse("first_pulse_clks");
        @(negedge clk);
        chk("pulse_width", int'(clk_nuevo), 0);
        chk("post_rst_pend", int'(pendientes), 0);

        // Pending latency: visible one clk after the call is sampled.
        do_reset(3, 4'b0000);
        llamada = 4'b0010;
        @(negedge clk);
        llamada = '0;
        chk("latch_latency", int'(pendientes), 4'b0010);

        run_scn(2);
        run_scn(3);
        run_scn(4);
        run_scn(5);

        // Reset while travelling between floors 1 and 2.
        do_reset(3, 4'b0000);
        llamada = 4'b1000;
        @(negedge clk);
        llamada = '0;
        repeat (3) wait_tick();
        chk("mv_piso_t3", int'(piso), 1);
        chk("mv_andando_t3", int'(state_andando), 1);
        wait_tick();
        rst     = 1'b1;
        llamada = 4'b1111;
        @(negedge clk);
        chk("mvrst_piso", int'(piso), 0);
        chk("mvrst_andando", int'(state_andando), 0);
        chk("mvrst_dir", int'(direccion), 0);
        chk("mvrst_pend", int'(pendientes), 0);
        chk("mvrst_clk_nuevo", int'(clk_nuevo), 0);
        rst     = 1'b0;
        llamada = '0;
        count_to_pulse("mvrst_divider_restart");
        chk("mvrst_pend_after", int'(pendientes), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
